score_tracker: RTL and testbench

//  Parametrised round/score counter for the elevator game; successor to the single-digit win counter.

---
 rtl/score_pkg.sv | 70 +++++++
 rtl/seg7_decode.sv | 25 ++
 rtl/score_tracker.sv | 94 +++++++++
 tb/tb_score_tracker.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types, 7-segment glyphs and BCD helpers for the score tracker.
// Scores are handled as up to four packed BCD digits; callers slice to their width.
package score_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [0:0] {
    PLAY = 1'b0,
    WON  = 1'b1
  } state_e;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int MAX_DIGITS = 4;

  // Decimal constant to four packed BCD digits, evaluated at elaboration.
  function automatic logic [15:0] to_bcd(input int value);
    logic [15:0] r;
    int          v;
    r = '0;
    v = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Add or subtract one with a digit-serial carry/borrow chain.
  // Callers guarantee no overflow past the top digit and no decrement of zero.
  function automatic logic [15:0] bcd_step(input logic [15:0] value, input logic up);
    logic [15:0] r;
    logic        chain;
    bcd_t        d;
    r     = value;
    chain = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      d = value[4*i +: 4];
      if (chain) begin
        if (up) begin
          if (d == 4'd9) d = 4'd0;
          else begin
            d     = d + 4'd1;
            chain = 1'b0;
          end
        end else begin
          if (d == 4'd0) d = 4'd9;
          else begin
            d     = d - 4'd1;
            chain = 1'b0;
          end
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit to an active-low 7-segment pattern; non-BCD codes blank the digit.
module seg7_decode
  import score_pkg::*;
(
  input  bcd_t       digit,
  output logic [6:0] seg
);

  always_comb begin
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_tracker.sv
// Edge-qualified BCD hit counter with optional miss penalty, sticky win at TARGET,
// a fixed-width next_round pulse per accepted hit, and per-digit 7-seg outputs.
module score_tracker
  import score_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int TARGET       = 15,
  parameter bit PENALTY_EN   = 1'b1,
  parameter int NEXT_ROUND_W = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          B,
  input  logic                          FL,
  input  logic                          OB,
  input  logic                          miss,
  input  logic                          clear,
  output logic [NUM_DIGITS-1:0][6:0]    HEX,
  output logic [4*NUM_DIGITS-1:0]       score,
  output logic                          next_round,
  output logic                          won
);

  localparam int          SW         = 4 * NUM_DIGITS;
  localparam logic [15:0] TARGET_BCD = to_bcd(TARGET);
  localparam logic [3:0]  PULSE_LEN  = 4'(NEXT_ROUND_W);

  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS || TARGET >= 10 ** NUM_DIGITS) begin : g_bad_param
    $error("score_tracker: NUM_DIGITS must be 1..4 and TARGET < 10**NUM_DIGITS");
  end

  state_e      state;
  logic        hit_q;
  logic        miss_q;
  logic [3:0]  pulse_cnt;

  logic        hit_lvl;
  logic        hit_evt;
  logic        miss_evt;
  logic        do_inc;
  logic        do_dec;
  logic [15:0] step_val;
  logic [SW-1:0] score_nxt;

  // NOTE: every signal driven in an always_comb gets a value on every path
  // (defaults first where branches are involved), otherwise a latch is inferred.
  always_comb begin
    hit_lvl  = B & FL & ~OB;
    hit_evt  = hit_lvl & ~hit_q;
    miss_evt = PENALTY_EN & miss & ~miss_q;
    // A hit and a miss landing together cancel out; an empty score absorbs a miss.
    do_inc   = (state == PLAY) & hit_evt & ~miss_evt;
    do_dec   = (state == PLAY) & miss_evt & ~hit_evt & (score != '0);
    step_val  = bcd_step(16'(score), do_inc);
    score_nxt = step_val[SW-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= PLAY;
      score     <= '0;
      pulse_cnt <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      // Edge detectors keep sampling through clear so a held level never re-counts.
      hit_q  <= hit_lvl;
      miss_q <= miss;
      if (clear) begin
        state     <= PLAY;
        score     <= '0;
        pulse_cnt <= '0;
      end else begin
        if (do_inc || do_dec) score <= score_nxt;
        if (do_inc && score_nxt == TARGET_BCD[SW-1:0]) state <= WON;
        if (do_inc)                 pulse_cnt <= PULSE_LEN;
        else if (pulse_cnt != '0)   pulse_cnt <= pulse_cnt - 4'd1;
      end
    end
  end

  assign next_round = (pulse_cnt != '0);
  assign won        = (state == WON);

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    seg7_decode u_seg (
      .digit (score[4*i +: 4]),
      .seg   (HEX[i])
    );
  end

endmodule

// File: tb/tb_score_tracker.sv
// Self-checking bench for score_tracker: directed scenarios with literal expectations
// plus a randomized run, all compared each cycle against an integer-valued score model.
module tb_score_tracker;

  localparam int ND   = 2;
  localparam int TGT  = 15;
  localparam int NR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              B = 1'b0, FL = 1'b0, OB = 1'b0, miss = 1'b0, clear = 1'b0;
  logic [ND-1:0][6:0] HEX;
  logic [4*ND-1:0]   score;
  logic              next_round;
  logic              won;

  int tests_run = 0;
  int tests_failed = 0;

  score_tracker #(
    .NUM_DIGITS   (ND),
    .TARGET       (TGT),
    .PENALTY_EN   (1'b1),
    .NEXT_ROUND_W (NR_W)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .B          (B),
    .FL         (FL),
    .OB         (OB),
    .miss       (miss),
    .clear      (clear),
    .HEX        (HEX),
    .score      (score),
    .next_round (next_round),
    .won        (won)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  default: return 7'b1111111;
    endcase
  endfunction

  // Reference model: score held as a plain integer, pulse as cycles remaining.
  int m_score = 0;
  bit m_won = 0;
  int m_pulse = 0;
  bit m_hit_prev = 0;
  bit m_miss_prev = 0;

  always @(posedge clk or negedge rst_n) begin
    bit hl, he, me;
    if (!rst_n) begin
      m_score = 0; m_won = 0; m_pulse = 0; m_hit_prev = 0; m_miss_prev = 0;
    end else begin
      hl = B && FL && !OB;
      he = hl && !m_hit_prev;
      me = miss && !m_miss_prev;
      m_hit_prev  = hl;
      m_miss_prev = miss;
      if (clear) begin
        m_score = 0; m_won = 0; m_pulse = 0;
      end else begin
        if (m_pulse > 0) m_pulse--;
        if (!m_won && he && !me) begin
          m_score++;
          m_pulse = NR_W;
          if (m_score == TGT) m_won = 1;
        end else if (!m_won && me && !he && m_score > 0) begin
          m_score--;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("score", 32'(score), 32'((m_score / 10) * 16 + (m_score % 10)));
    check("won", 32'(won), 32'(m_won));
    check("next_round", 32'(next_round), 32'(m_pulse > 0));
    check("hex0", 32'(HEX[0]), 32'(glyph(m_score % 10)));
    check("hex1", 32'(HEX[1]), 32'(glyph(m_score / 10)));
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hit();
    B = 1'b1; FL = 1'b1; OB = 1'b0;
    step();
    B = 1'b0;
    step();
  endtask

  int nr_count;

  initial begin
    step(2);
    rst_n = 1'b1;
    step();
    check("reset_score", 32'(score), 32'h00);
    check("reset_hex0", 32'(HEX[0]), 32'b1000000);

    // Asynchronous reset in mid-count.
    repeat (7) hit();
    check("pre_reset_07", 32'(score), 32'h07);
    #2 rst_n = 1'b0;
    #1;
    check("async_score", 32'(score), 32'h00);
    check("async_hex0", 32'(HEX[0]), 32'b1000000);
    check("async_nr", 32'(next_round), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Held hit level counts once, pulse lasts NR_W cycles.
    B = 1'b1; FL = 1'b1; OB = 1'b0;
    nr_count = 0;
    repeat (10) begin
      step();
      if (next_round) nr_count++;
    end
    B = 1'b0;
    step();
    check("held_once", 32'(score), 32'h01);
    check("pulse_width", 32'(nr_count), 32'(NR_W));

    // Carry into the tens digit.
    repeat (9) hit();
    check("ten_score", 32'(score), 32'h10);
    check("ten_hex1", 32'(HEX[1]), 32'b1111001);
    check("ten_hex0", 32'(HEX[0]), 32'b1000000);

    // Miss penalty with borrow, then simultaneous hit and miss cancel.
    miss = 1'b1; step(); miss = 1'b0; step();
    check("borrow_09", 32'(score), 32'h09);
    hit();
    B = 1'b1; FL = 1'b1; miss = 1'b1;
    step();
    check("cancel_score", 32'(score), 32'h10);
    B = 1'b0; miss = 1'b0;
    step(4);
    check("cancel_no_pulse", 32'(next_round), 32'd0);

    // Reach the target, then verify the freeze.
    repeat (4) hit();
    check("won_before", 32'(won), 32'd0);
    B = 1'b1; FL = 1'b1;
    step();
    check("won_same_cycle", 32'(won), 32'd1);
    check("won_score", 32'(score), 32'h15);
    B = 1'b0;
    step(4);
    nr_count = 0;
    repeat (3) begin
      B = 1'b1; step(); if (next_round) nr_count++;
      B = 1'b0; step(); if (next_round) nr_count++;
    end
    check("frozen_score", 32'(score), 32'h15);
    check("frozen_no_pulse", 32'(nr_count), 32'd0);
    clear = 1'b1; step(); clear = 1'b0;
    check("clear_score", 32'(score), 32'h00);
    check("clear_won", 32'(won), 32'd0);

    // Miss at zero stays zero.
    miss = 1'b1; step(); miss = 1'b0; step();
    check("floor_zero", 32'(score), 32'h00);

    // Obstacle blocks the hit; dropping it creates one edge.
    B = 1'b1; FL = 1'b1; OB = 1'b1;
    step(3);
    check("obstacle_block", 32'(score), 32'h00);
    OB = 1'b0;
    step();
    check("obstacle_drop", 32'(score), 32'h01);
    step(3);
    check("obstacle_hold", 32'(score), 32'h01);

    // Level held through clear does not count afterwards.
    clear = 1'b1; step(); clear = 1'b0;
    step(3);
    check("clear_held", 32'(score), 32'h00);
    B = 1'b0; FL = 1'b0;
    step();

    // Randomized traffic against the model.
    repeat (3000) begin
      B     = ($urandom_range(0, 1) == 1);
      FL    = ($urandom_range(0, 3) != 0);
      OB    = ($urandom_range(0, 3) == 0);
      miss  = ($urandom_range(0, 6) == 0);
      clear = ($urandom_range(0, 59) == 0);
      step();
    end
    B = 1'b0; FL = 1'b0; OB = 1'b0; miss = 1'b0; clear = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
